// File: rtl/mt_pkg.sv
// Shared types and pointer-field layout for the mapping-table pointer sequencer.
package mt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam logic [31:0] SKIP_PTR = 32'hFFFF_FFFF;
  localparam int WAY_MSB = 31;
  localparam int WAY_LSB = 28;
  localparam int ROW_MSB = 27;

  typedef struct packed {
    logic [3:0]  way;
    logic [31:0] row;
  } cmd_t;

  function automatic cmd_t decode_ptr(input logic [31:0] ptr);
    cmd_t c;
    c.way = ptr[WAY_MSB:WAY_LSB];
    c.row = {4'b0, ptr[ROW_MSB:0]};
    return c;
  endfunction

endpackage

// File: rtl/mt_rd_lat_ctr.sv
// BRAM read-latency timer: down-counter loaded on the read cycle, capture strobe at terminal count.
module mt_rd_lat_ctr #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic active,
  output logic capture
);

  localparam logic [1:0] LOAD_VAL = 2'(RD_LAT - 1);

  logic [1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (active && (cnt_q != 2'd0)) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  assign capture = active && (cnt_q == 2'd0);

endmodule

// File: rtl/mt_pointer_sequencer.sv
// Walks a BRAM table of packed flash pointers and offers each non-skip entry as a way/row command.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_READ  | one-cycle BRAM read of entry idx
//   S_WAIT  | RD_LAT cycles until read data is valid, captured on the last one
//   S_ISSUE | command offered, held until cmd_ready
//   S_DONE  | one-cycle completion pulse
module mt_pointer_sequencer
  import mt_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h4580_0000,
  parameter int          ENTRY_NUM  = 32,
  parameter int          RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  entry_cnt,
  output logic        ram_clk,
  output logic        ram_rst,
  output logic [31:0] ram_addr,
  output logic        ram_en,
  input  logic [31:0] ram_rd_data,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_wd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_way,
  output logic [31:0] cmd_row,
  output logic [5:0]  cmd_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [6:0] MAX_CNT = 7'(ENTRY_NUM);

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] ptr_q, ptr_d;
  logic [5:0]  cnt_clamp;
  logic [5:0]  last_idx;
  logic        capture;
  cmd_t        cmd;

  assign cnt_clamp = ({1'b0, entry_cnt} > MAX_CNT) ? MAX_CNT[5:0] : entry_cnt;
  assign last_idx  = cnt_q - 6'd1;

  mt_rd_lat_ctr #(.RD_LAT(RD_LAT)) u_rd_lat_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state_q == S_READ),
    .active  (state_q == S_WAIT),
    .capture (capture)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 6'd0;
      cnt_q    <= 6'd0;
      ptr_q    <= 32'd0;
      ram_addr <= START_ADDR;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      ram_addr <= START_ADDR + {24'd0, idx_d, 2'b00};
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = cnt_clamp;
          idx_d   = 6'd0;
          state_d = (cnt_clamp == 6'd0) ? S_DONE : S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        if (capture) begin
          // Skip entries leave the last offered command fields untouched.
          if (ram_rd_data == SKIP_PTR) begin
            if (idx_q == last_idx) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 6'd1;
              state_d = S_READ;
            end
          end else begin
            ptr_d   = ram_rd_data;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          if (idx_q == last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd         = decode_ptr(ptr_q);
  assign cmd_way     = cmd.way;
  assign cmd_row     = cmd.row;
  assign cmd_idx     = idx_q;
  assign cmd_valid   = (state_q == S_ISSUE);
  assign ram_en      = (state_q == S_READ);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign ram_clk     = clk;
  assign ram_rst     = ~rst_n;
  assign ram_we      = 4'd0;
  assign ram_wd_data = 32'd0;

endmodule

// File: tb/tb_mt_pointer_sequencer.sv
// Scoreboard bench for mt_pointer_sequencer: BRAM model with 2-cycle latency, queued expected commands.
module tb_mt_pointer_sequencer;

  localparam logic [31:0] START = 32'h4580_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  entry_cnt = 6'd0;
  logic        cmd_ready = 1'b1;
  logic        ram_clk, ram_rst, ram_en, cmd_valid, busy, done;
  logic [31:0] ram_addr, ram_rd_data, ram_wd_data, cmd_row;
  logic [3:0]  ram_we, cmd_way;
  logic [5:0]  cmd_idx;

  mt_pointer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .entry_cnt(entry_cnt),
    .ram_clk(ram_clk), .ram_rst(ram_rst), .ram_addr(ram_addr), .ram_en(ram_en),
    .ram_rd_data(ram_rd_data), .ram_we(ram_we), .ram_wd_data(ram_wd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_way(cmd_way), .cmd_row(cmd_row),
    .cmd_idx(cmd_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [31:0] mem [32];
  logic [31:0] d1 = 32'd0, d2 = 32'd0;
  logic [31:0] off;
  assign off = ram_addr - START;
  assign ram_rd_data = d2;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) d1 <= mem[off[6:2]];
    d2 <= d1;
  end

  typedef struct packed {
    logic [3:0]  way;
    logic [31:0] row;
    logic [5:0]  idx;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int          hs_k[$];
  int          first_k = 0, done_k = 0, done_cnt = 0, en_cnt = 0;
  logic [31:0] last_addr = 32'd0;
  logic        stall_q = 1'b0;
  logic [41:0] held_q = 42'd0;

  always @(negedge clk) begin
    int k;
    exp_t e;
    k = cyc - start_cyc + 1;
    if (stall_q) begin
      chk("hold_valid", 64'(cmd_valid), 64'd1);
      chk("hold_fields", 64'({cmd_way, cmd_row, cmd_idx}), 64'(held_q));
      chk("hold_no_read", 64'(ram_en), 64'd0);
    end
    stall_q = rst_n && cmd_valid && !cmd_ready;
    held_q  = {cmd_way, cmd_row, cmd_idx};
    if (rst_n && cmd_valid && first_k == 0) first_k = k;
    if (rst_n && ram_en) begin
      en_cnt++;
      last_addr = ram_addr;
    end
    if (rst_n && done) begin
      done_cnt++;
      done_k = k;
    end
    if (rst_n && cmd_valid && cmd_ready) begin
      hs_k.push_back(k);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cmd: got idx %0d expected no command", cmd_idx);
      end else begin
        e = sb.pop_front();
        chk("cmd_fields", 64'({cmd_way, cmd_row, cmd_idx}), 64'(e));
      end
    end
  end

  int bp_left = 0;
  logic hold_low = 1'b0;
  always @(posedge clk) begin
    #1;
    if (hold_low) cmd_ready = 1'b0;
    else if (bp_left > 0 && cmd_valid && cmd_idx == 6'd1) begin
      cmd_ready = 1'b0;
      bp_left--;
    end else cmd_ready = 1'b1;
  end

  task automatic run_walk(input int n);
    int m;
    hs_k.delete();
    first_k = 0; done_k = 0; done_cnt = 0; en_cnt = 0;
    m = (n > 32) ? 32 : n;
    for (int i = 0; i < m; i++)
      if (mem[i] != 32'hFFFF_FFFF)
        sb.push_back({mem[i][31:28], {4'b0, mem[i][27:0]}, 6'(i)});
    @(posedge clk); #1;
    start = 1'b1;
    entry_cnt = 6'(n);
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done within 2000 cycles");
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic finish_walk(input string nm, input int e_hs[$], input int e_done, input int e_en, input int e_first);
    chk({nm, "_hs_count"}, 64'(hs_k.size()), 64'(e_hs.size()));
    for (int i = 0; i < e_hs.size() && i < hs_k.size(); i++)
      chk({nm, "_hs_cycle"}, 64'(hs_k[i]), 64'(e_hs[i]));
    chk({nm, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({nm, "_done_cycle"}, 64'(done_k), 64'(e_done));
    chk({nm, "_ram_en_count"}, 64'(en_cnt), 64'(e_en));
    chk({nm, "_first_valid"}, 64'(first_k), 64'(e_first));
    chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int e[$];
    int t;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[0] = 32'h1000_0010;
    mem[1] = 32'h2000_0020;
    mem[2] = 32'h3000_0030;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'(START));
    chk("rst_cmd_fields", 64'({cmd_way, cmd_row, cmd_idx}), 64'd0);
    chk("rst_ram_rst", 64'(ram_rst), 64'd1);
    chk("ram_we", 64'({ram_we, ram_wd_data}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ram_rst_release", 64'(ram_rst), 64'd0);

    // basic walk
    run_walk(3);
    wait_end();
    e = '{4, 8, 12};
    finish_walk("basic", e, 13, 3, 4);

    // backpressure on entry 1
    bp_left = 5;
    run_walk(3);
    wait_end();
    e = '{4, 13, 17};
    finish_walk("bp", e, 18, 3, 4);

    // skip entry
    mem[1] = 32'hFFFF_FFFF;
    run_walk(3);
    wait_end();
    e = '{4, 11};
    finish_walk("skip", e, 12, 3, 4);

    // empty table
    run_walk(0);
    wait_end();
    e.delete();
    finish_walk("zero", e, 1, 0, 0);

    // clamp to 32
    for (int i = 0; i < 32; i++) mem[i] = {4'(i % 15 + 1), 28'(i * 257 + 3)};
    run_walk(40);
    wait_end();
    e.delete();
    for (int i = 0; i < 32; i++) e.push_back(4 + 4 * i);
    finish_walk("clamp", e, 129, 32, 4);
    chk("clamp_last_addr", 64'(last_addr), 64'(START + 32'h7C));

    // reset during ISSUE
    mem[0] = 32'h1000_0010;
    mem[1] = 32'h2000_0020;
    mem[2] = 32'h3000_0030;
    hold_low = 1'b1;
    run_walk(3);
    t = 0;
    while (!cmd_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_valid) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got no cmd_valid expected cmd_valid within 50 cycles");
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ram_addr", 64'(ram_addr), 64'(START));
    chk("midrst_cmd_idx", 64'(cmd_idx), 64'd0);
    sb.delete();
    hold_low = 1'b0;
    repeat (2) @(posedge clk);
    run_walk(3);
    wait_end();
    e = '{4, 8, 12};
    finish_walk("after_rst", e, 13, 3, 4);

    // start while busy
    mem[0] = 32'h5000_0050;
    run_walk(1);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_end();
    e = '{4};
    finish_walk("busy_start", e, 5, 1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
